// File: rtl/muldiv_seq_if.sv
// Start/ready bundle between the EX stage and the multi-cycle sequencer.
// EX drives the request side; the sequencer returns stall, result and status.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic [2:0]         op_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] hilo_i;
  logic               annul_i;
  logic               stallreq_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;
  logic               div_by_zero_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i,
    output hilo_i, annul_i,
    input  stallreq_o, ready_o, result_o,
    input  div_by_zero_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i,
    input  hilo_i, annul_i,
    output stallreq_o, ready_o, result_o,
    output div_by_zero_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MADD/MSUB accumulate and restoring divide beside EX.
// Holds the pipeline via stallreq_o until the {HI,LO} result is handed back.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE, ACC, DIV_ON, DIV_ZERO, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic [W2-1:0]    res_q, res_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sub_q, sub_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_q, dbz_d;
  logic             stall;

  logic             legal, accept, sgn;
  logic [WIDTH-1:0] a, b, a_abs, b_abs;
  logic [W2-1:0]    ext_a, ext_b, acc;
  logic [WIDTH:0]   shl, diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  assign a      = bus.opdata1_i;
  assign b      = bus.opdata2_i;
  assign legal  = ~(bus.op_i[2] & bus.op_i[1]);
  assign accept = bus.start_i & ~bus.annul_i & legal;
  assign sgn    = ~bus.op_i[0];

  assign ext_a = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign ext_b = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign a_abs = (sgn & a[WIDTH-1]) ? -a : a;
  assign b_abs = (sgn & b[WIDTH-1]) ? -b : b;
  assign acc   = sub_q ? bus.hilo_i - prod_q : bus.hilo_i + prod_q;

  // diff MSB set means the trial subtraction went negative: restore
  assign shl    = {rem_q, dvd_q[WIDTH-1]};
  assign diff   = shl - {1'b0, dvs_q};
  assign qbit   = ~diff[WIDTH];
  assign rem_nx = qbit ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
  assign quo_nx = {dvd_q[WIDTH-2:0], qbit};

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    res_d   = res_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = accept;
        if (accept) begin
          if (!bus.op_i[2]) begin
            prod_d  = ext_a * ext_b;
            sub_d   = bus.op_i[1];
            state_d = ACC;
          end else if (b == '0) begin
            state_d = DIV_ZERO;
          end else begin
            dvd_d   = a_abs;
            dvs_d   = b_abs;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d  = sgn & a[WIDTH-1];
            state_d = DIV_ON;
          end
        end
      end
      ACC: begin
        stall   = 1'b1;
        res_d   = acc;
        state_d = DONE;
      end
      DIV_ON: begin
        stall = 1'b1;
        rem_d = rem_nx;
        dvd_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d[W2-1:WIDTH] = rneg_q ? -rem_nx : rem_nx;
          res_d[WIDTH-1:0]  = qneg_q ? -quo_nx : quo_nx;
          state_d = DONE;
        end
      end
      DIV_ZERO: begin
        stall   = 1'b1;
        res_d   = '0;
        dbz_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!bus.start_i) begin
          dbz_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a flush abandons any in-flight op without touching the last result
    if (bus.annul_i && state_q != IDLE) begin
      stall   = 1'b0;
      res_d   = res_q;
      dbz_d   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prod_q  <= '0;
      res_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.stallreq_o    = stall;
  assign bus.ready_o       = (state_q == DONE);
  assign bus.result_o      = res_q;
  assign bus.div_by_zero_o = dbz_q;
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle arithmetic sequencer beside the EX stage of the 5-stage MIPS pipeline.
- Executes MADD/MADDU/MSUB/MSUBU as multiply then accumulate, and DIV/DIVU as a WIDTH-step restoring divider.
- Raises a stall request while busy and hands the 64-bit HI/LO result back to EX with a start/ready handshake.
- Replaces the cnt/hilo_temp round-trip through ID/EX for multi-cycle ops.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH; divider runs WIDTH iterations.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  EX requests operation; held high until ready_o seen.
- op_i  in  3  operation: 000 MADD, 001 MADDU, 010 MSUB, 011 MSUBU, 100 DIV, 101 DIVU; 110/111 illegal.
- opdata1_i  in  WIDTH  multiplicand / dividend.
- opdata2_i  in  WIDTH  multiplier / divisor.
- hilo_i  in  2*WIDTH  forwarded {HI,LO} (MEM/WB-bypassed by EX).
- annul_i  in  1  flush; abandons current operation.
- stallreq_o  out  1  pipeline stall request (combinational).
- ready_o  out  1  result valid.
- result_o  out  2*WIDTH  MADD/MSUB: new {HI,LO}; DIV: {remainder, quotient}.
- div_by_zero_o  out  1  set with ready_o when the divisor was 0.

Behaviour:
- States: IDLE, ACC, DIV_ON, DIV_ZERO, DONE.
- Reset: state=IDLE; ready_o=0, result_o=0, div_by_zero_o=0, internal count and registers 0.
- Reset mid-operation aborts the operation. No ready_o is produced.

IDLE:
- Accepts when start_i=1, annul_i=0 and op_i is legal. Illegal op or annul: stay IDLE, no stall.
- Mult ops: register the full 2*WIDTH product, then go to ACC.
  - Signed ops (MADD, MSUB): two's-complement product.
  - Unsigned ops: unsigned product.
- DIV/DIVU with opdata2_i==0: go to DIV_ZERO.
- Other DIV/DIVU: latch divisor, dividend and sign flags; clear partial remainder; cnt=0; go to DIV_ON.
  - DIV uses absolute values. DIVU uses raw values.

ACC (one cycle):
- Samples hilo_i in this cycle.
- MADD*: acc = hilo_i + prod. MSUB*: acc = hilo_i - prod. Both modulo 2^(2*WIDTH).
- result_o <= acc; go to DONE.

DIV_ON:
- One restoring step per cycle: shift the partial remainder left, bringing in the next dividend MSB; subtract the divisor if the result is non-negative; the quotient bit is 1 on subtract.
- cnt increments each cycle. The step with cnt==WIDTH-1 also applies sign fixup, loads result_o, and goes to DONE.
- DIV sign fixup:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- DIVU: no fixup.
- Overflow case 0x80000000 / -1 gives quotient 0x80000000, remainder 0 (natural wrap).

DIV_ZERO:
- result_o <= 0; div_by_zero_o <= 1; go to DONE.

DONE:
- ready_o=1; result_o and div_by_zero_o held stable.
- Stays in DONE while start_i=1. When start_i=0: next state IDLE with ready_o=0, div_by_zero_o=0; result_o retains its value.
- A start_i re-asserted in the same cycle ready_o falls is treated as a new request at IDLE.

Latency (accept cycle = N):
- Mult ops: ACC at N+1, ready_o at N+2.
- DIV: DIV_ON at N+1..N+WIDTH, ready_o at N+WIDTH+1 (N+33 for WIDTH=32).
- Divide by zero: ready_o at N+2.

stallreq_o:
- 1 in IDLE when an op is being accepted.
- 1 in ACC, DIV_ON and DIV_ZERO.
- 0 in DONE, and 0 in any busy state while annul_i=1.

annul_i:
- In ACC, DIV_ON or DIV_ZERO: next state IDLE, ready_o never asserted.
- In DONE: next state IDLE, ready_o=0.
- annul_i takes priority over normal transitions. rst takes priority over annul_i.

Operands:
- opdata*_i are sampled only at accept; changes afterwards are ignored.

Test Plan:
- MADD accumulate:
  - Stimulus: op=000, a=0xFFFFFFFF, b=0x00000002, hilo_i=0x0000000000000005.
  - Required: stallreq_o=1 at N and N+1; ready_o=1 at N+2; result_o=0x0000000000000003.
- MSUBU wrap:
  - Stimulus: op=011, a=b=0xFFFFFFFF, hilo_i=0.
  - Required: product 0xFFFFFFFE00000001; result_o=0x00000001FFFFFFFF at N+2.
- Signed DIV:
  - Stimulus: op=100, a=0xFFFFFFF9 (-7), b=0x00000002.
  - Required: ready_o first at N+33; result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3); div_by_zero_o=0.
- DIVU by zero:
  - Stimulus: op=101, a=0x12345678, b=0.
  - Required: ready_o at N+2; result_o=0; div_by_zero_o=1.
- Annul mid-divide:
  - Stimulus: DIVU 100/7; annul_i pulse at N+10.
  - Required: IDLE at N+11; stallreq_o=0 from N+10; ready_o never 1.
  - Follow-up: a new DIVU 100/7 gives result_o=0x00000002_0000000E at its N+33.
- Handshake hold and reset:
  - Stimulus: hold start_i 3 cycles after ready_o, then drop.
  - Required: result_o stable across those cycles; ready_o=0 the cycle after start_i drops.
  - Stimulus: assert rst at N+5 of a DIV.
  - Required: all outputs 0 next cycle; state IDLE.
